// File: rtl/waterloo_text_sequencer.sv
// Frame-synchronous animation controller for the WATERLOO ENG overlay:
// looping typewriter reveal, hold, blink and blank gap, updated only on frame_tick.
module waterloo_text_sequencer #(
    parameter int NUM_CHARS       = 12,
    parameter int FRAMES_PER_CHAR = 6,
    parameter int HOLD_FRAMES     = 120,
    parameter int BLINK_FRAMES    = 15,
    parameter int BLINK_TOGGLES   = 6,
    parameter int GAP_FRAMES      = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       restart,
    output logic [3:0] visible_chars,
    output logic       text_visible,
    output logic       cycle_done,
    output logic [2:0] phase
);

    localparam int MAX_AB     = (FRAMES_PER_CHAR > HOLD_FRAMES) ? FRAMES_PER_CHAR : HOLD_FRAMES;
    localparam int MAX_CD     = (BLINK_FRAMES > GAP_FRAMES) ? BLINK_FRAMES : GAP_FRAMES;
    localparam int MAX_FRAMES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int FC_W       = $clog2(MAX_FRAMES) + 1;
    localparam int TC_W       = $clog2(BLINK_TOGGLES) + 1;

    localparam logic [FC_W-1:0] CHAR_LAST  = FC_W'(FRAMES_PER_CHAR - 1);
    localparam logic [FC_W-1:0] HOLD_LAST  = FC_W'(HOLD_FRAMES - 1);
    localparam logic [FC_W-1:0] BLINK_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [FC_W-1:0] GAP_LAST   = FC_W'(GAP_FRAMES - 1);
    localparam logic [TC_W-1:0] TOG_LAST   = TC_W'(BLINK_TOGGLES - 1);
    localparam logic [3:0]      CHAR_FINAL = 4'(NUM_CHARS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REVEAL = 3'd1,
        HOLD   = 3'd2,
        BLINK  = 3'd3,
        GAP    = 3'd4
    } state_t;

    state_t          state;
    logic [FC_W-1:0] frame_cnt;
    logic [TC_W-1:0] toggle_cnt;
    logic            restart_pend;

    assign phase = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            visible_chars <= 4'd0;
            text_visible  <= 1'b0;
            cycle_done    <= 1'b0;
            frame_cnt     <= '0;
            toggle_cnt    <= '0;
            restart_pend  <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (frame_tick) begin
                restart_pend <= 1'b0;
                if (!enable) begin
                    state         <= IDLE;
                    visible_chars <= 4'd0;
                    text_visible  <= 1'b0;
                    frame_cnt     <= '0;
                end else if (restart_pend || restart) begin
                    state         <= REVEAL;
                    visible_chars <= 4'd0;
                    text_visible  <= 1'b1;
                    frame_cnt     <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            state         <= REVEAL;
                            visible_chars <= 4'd0;
                            text_visible  <= 1'b1;
                            frame_cnt     <= '0;
                        end
                        REVEAL: begin
                            if (frame_cnt == CHAR_LAST) begin
                                frame_cnt     <= '0;
                                visible_chars <= visible_chars + 4'd1;
                                if (visible_chars == CHAR_FINAL) state <= HOLD;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                        HOLD: begin
                            if (frame_cnt == HOLD_LAST) begin
                                state      <= BLINK;
                                frame_cnt  <= '0;
                                toggle_cnt <= '0;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                        BLINK: begin
                            if (frame_cnt == BLINK_LAST) begin
                                frame_cnt  <= '0;
                                toggle_cnt <= toggle_cnt + 1'b1;
                                // The final toggle lands in GAP rather than flipping visibility
                                if (toggle_cnt == TOG_LAST) begin
                                    state         <= GAP;
                                    text_visible  <= 1'b0;
                                    visible_chars <= 4'd0;
                                end else begin
                                    text_visible <= ~text_visible;
                                end
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                        GAP: begin
                            if (frame_cnt == GAP_LAST) begin
                                state        <= REVEAL;
                                frame_cnt    <= '0;
                                text_visible <= 1'b1;
                                cycle_done   <= 1'b1;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                        default: begin
                            state         <= IDLE;
                            visible_chars <= 4'd0;
                            text_visible  <= 1'b0;
                            frame_cnt     <= '0;
                        end
                    endcase
                end
            end else if (restart) begin
                restart_pend <= 1'b1;
            end
        end
    end

endmodule
